// File: rtl/fft_frame_buffer_if.sv
// Stream interface for fft_frame_buffer: sample input strobe/data,
// valid/ready output stream with frame marker, and sticky overflow flag.
interface fft_frame_buffer_if #(
    parameter int DATA_WIDTH = 14
);
    logic                         en;
    logic signed [DATA_WIDTH-1:0] di;
    logic                         ready;
    logic                         valid;
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         last;
    logic                         overflow;

    // Producer/consumer side (window stage + FFT, or a testbench)
    modport master (
        output en, di, ready,
        input  valid, dout, last, overflow
    );

    // Frame buffer side
    modport slave (
        input  en, di, ready,
        output valid, dout, last, overflow
    );
endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer between the window stage and the FFT.
// Two N-deep banks: one fills from the window stage while the other is
// streamed out with a valid/ready handshake.
// Optional macro FFT_FRAME_BUFFER_BITREV_EN: when defined the read address
// is the bit-reversed read counter (DIT order); otherwise natural order.
module fft_frame_buffer #(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_frame_buffer_if.slave    bus
);
    localparam int AW = $clog2(N);

    // Write-side state
    logic [AW-1:0] wr_ctr_q, wr_ctr_d;
    logic          wr_bank_q, wr_bank_d;
    logic          wr_accept_q, wr_accept_d;
    logic          overflow_q, overflow_d;
    logic [1:0]    full_q, full_d;

    // Read-side state
    logic [AW-1:0] rd_ctr_q, rd_ctr_d;
    logic          rd_bank_q, rd_bank_d;
    logic          pend_q, pend_d;
    logic          pend_last_q, pend_last_d;

    // Output register
    logic                         valid_q, valid_d;
    logic                         last_q, last_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;

    // Storage: both banks in one array, bank selects the address MSB
    logic [DATA_WIDTH-1:0] mem [0:2*N-1];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [AW-1:0]         rd_addr;

    // Handshake / control terms
    logic frame_start;
    logic accept;
    logic wr_fire;
    logic wr_done;
    logic out_stall;
    logic rd_fire;
    logic rd_done;

`ifdef FFT_FRAME_BUFFER_BITREV_EN
    // Read address is the read counter with its bits reversed
    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
            assign rd_addr[gi] = rd_ctr_q[AW-1-gi];
        end
    endgenerate
`else
    assign rd_addr = rd_ctr_q;
`endif

    // Decide this cycle's writes and reads
    always_comb begin
        frame_start = bus.en && (wr_ctr_q == '0);
        // Accept/reject is decided on a frame's first sample and held after
        accept      = frame_start ? !full_q[wr_bank_q] : wr_accept_q;
        wr_fire     = bus.en && accept;
        wr_done     = wr_fire && (wr_ctr_q == AW'(N-1));
        // A held output word blocks any new read
        out_stall   = valid_q && !bus.ready;
        rd_fire     = full_q[rd_bank_q] && !out_stall;
        rd_done     = rd_fire && (rd_ctr_q == AW'(N-1));
    end

    // Next-state for counters, bank pointers, full flags and overflow
    always_comb begin
        wr_ctr_d    = bus.en ? wr_ctr_q + AW'(1) : wr_ctr_q;
        wr_accept_d = accept;
        wr_bank_d   = wr_done ? ~wr_bank_q : wr_bank_q;
        overflow_d  = overflow_q | (frame_start && full_q[wr_bank_q]);

        rd_ctr_d    = rd_fire ? rd_ctr_q + AW'(1) : rd_ctr_q;
        rd_bank_d   = rd_done ? ~rd_bank_q : rd_bank_q;

        // Completions on both sides always hit different banks
        full_d = full_q;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
    end

    // Next-state for the read pipeline and output register
    always_comb begin
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        valid_d     = valid_q;
        last_d      = last_q;
        dout_d      = dout_q;
        if (!out_stall) begin
            pend_d      = rd_fire;
            pend_last_d = rd_fire && (rd_ctr_q == AW'(N-1));
            valid_d     = pend_q;
            last_d      = pend_q && pend_last_q;
            if (pend_q) dout_d = $signed(rd_data_q);
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ctr_q    <= '0;
            wr_bank_q   <= 1'b0;
            wr_accept_q <= 1'b0;
            overflow_q  <= 1'b0;
            full_q      <= 2'b00;
            rd_ctr_q    <= '0;
            rd_bank_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ctr_q    <= wr_ctr_d;
            wr_bank_q   <= wr_bank_d;
            wr_accept_q <= wr_accept_d;
            overflow_q  <= overflow_d;
            full_q      <= full_d;
            rd_ctr_q    <= rd_ctr_d;
            rd_bank_q   <= rd_bank_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            dout_q      <= dout_d;
        end
    end

    // Bank RAM: one write port, one registered read port, no reset
    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank_q, wr_ctr_q}] <= bus.di;
        if (rd_fire) rd_data_q <= mem[{rd_bank_q, rd_addr}];
    end

    assign bus.valid    = valid_q;
    assign bus.last     = last_q;
    assign bus.dout     = dout_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer with N=8, DATA_WIDTH=14.
// Expected words are queued at stimulus time; a negedge monitor pops and
// compares on every transfer and checks stability while stalled.
module tb_fft_frame_buffer;
    localparam int N  = 8;
    localparam int DW = 14;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_frame_buffer_if #(.DATA_WIDTH(DW)) bus ();

    fft_frame_buffer #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int data;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_cyc_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    function automatic int out_index(input int k);
        int r;
`ifdef FFT_FRAME_BUFFER_BITREV_EN
        r = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
        r = k;
`endif
        return r;
    endfunction

    // Monitor: compare transfers, check hold behaviour under back-pressure
    logic           prev_valid, prev_ready, prev_last;
    logic [DW-1:0]  prev_dout;
    initial begin
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_last  = 1'b0;
        prev_dout  = '0;
    end
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_n) begin
            if (prev_valid && !prev_ready) begin
                check("stall_valid", int'(bus.valid), 1);
                check("stall_dout", int'(bus.dout), int'(prev_dout));
                check("stall_last", int'(bus.last), int'(prev_last));
            end
            if (bus.valid && bus.ready) begin
                xfer_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", int'(bus.dout), -1);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer cyc=%0d dout=%0d last=%0d", cyc, bus.dout, bus.last);
                    check("dout", int'($signed(bus.dout)), e.data);
                    check("last", int'(bus.last), e.last);
                end
            end
            prev_valid = bus.valid;
            prev_ready = bus.ready;
            prev_dout  = bus.dout;
            prev_last  = bus.last;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int base);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.data = base + out_index(k);
            e.last = (k == N-1) ? 1 : 0;
            exp_q.push_back(e);
        end
    endtask

    // Writes N consecutive samples base..base+N-1; optionally expects them out
    task automatic write_frame(input int base, input bit expect_out);
        if (expect_out) push_frame(base);
        for (int i = 0; i < N; i++) begin
            bus.en = 1'b1;
            bus.di = DW'(base + i);
            tick();
        end
        bus.en = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
        check("drain_remaining", exp_q.size(), 0);
    endtask

    int pat[4];
    int start_idx;

    initial begin
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.di   = '0;
        bus.ready = 1'b1;

        // 1: reset state with random input activity
        for (int i = 0; i < 3; i++) begin
            bus.en = 1'($urandom_range(0, 1));
            bus.di = DW'($urandom);
            tick();
            check("rst_valid", int'(bus.valid), 0);
            check("rst_last", int'(bus.last), 0);
            check("rst_dout", int'(bus.dout), 0);
            check("rst_overflow", int'(bus.overflow), 0);
        end
        bus.en = 1'b0;
        rst_n  = 1'b1;
        tick();
        check("post_rst_valid", int'(bus.valid), 0);
        check("post_rst_dout", int'(bus.dout), 0);
        check("post_rst_overflow", int'(bus.overflow), 0);

        // 2: single frame, latency of two edges after the last write
        write_frame(0, 1'b1);
        tick();
        check("latency_valid_t1", int'(bus.valid), 0);
        tick();
        check("latency_valid_t2", int'(bus.valid), 1);
        drain(40);

        // 3: back-pressure with ready pattern 1,0,0,1
        write_frame(100, 1'b1);
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            bus.ready = pat[c % 4][0];
            tick();
        end
        check("bp_remaining", exp_q.size(), 0);
        bus.ready = 1'b1;
        repeat (4) tick();

        // 4: continuous streaming, 4 frames back to back
        start_idx = xfer_cyc_q.size();
        for (int f = 0; f < 4; f++) push_frame(f * N);
        for (int i = 0; i < 4 * N; i++) begin
            bus.en = 1'b1;
            bus.di = DW'(i);
            tick();
        end
        bus.en = 1'b0;
        drain(60);
        if (xfer_cyc_q.size() >= start_idx + 4 * N)
            check("stream_gapless_span",
                  xfer_cyc_q[start_idx + 4*N - 1] - xfer_cyc_q[start_idx], 4*N - 1);
        else
            check("stream_word_count", xfer_cyc_q.size() - start_idx, 4 * N);
        check("stream_overflow", int'(bus.overflow), 0);

        // 5: overflow drop with output stalled
        bus.ready = 1'b0;
        write_frame(0, 1'b1);
        write_frame(8, 1'b1);
        check("ovf_before_drop", int'(bus.overflow), 0);
        bus.en = 1'b1;
        bus.di = DW'(16);
        tick();
        check("ovf_after_drop", int'(bus.overflow), 1);
        for (int i = 17; i < 24; i++) begin
            bus.di = DW'(i);
            tick();
        end
        bus.en = 1'b0;
        bus.ready = 1'b1;
        drain(60);
        write_frame(24, 1'b1);
        drain(40);
        check("ovf_sticky", int'(bus.overflow), 1);

        // 6: reset during output
        start_idx = xfer_cyc_q.size();
        write_frame(32, 1'b1);
        for (int i = 0; i < 40 && xfer_cyc_q.size() < start_idx + 3; i++) tick();
        check("pre_reset_xfers", xfer_cyc_q.size() - start_idx, 3);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("midrst_valid", int'(bus.valid), 0);
        check("midrst_overflow", int'(bus.overflow), 0);
        rst_n = 1'b1;
        tick();
        write_frame(40, 1'b1);
        drain(40);
        repeat (5) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
